// File: rtl/stack_ctrl_if.sv
// Stack-operation handshake and data-memory beat signals shared by the CPU
// controller (master) and the stack responder (slave).
interface stack_ctrl_if;
  logic       stack_op_ongoing;
  logic       push_or_pop;
  logic       stack_op_end;
  logic       bus_grant;
  logic [7:0] push_pc;
  logic [7:0] push_flags;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic [7:0] pop_pc;
  logic [7:0] pop_flags;
  logic       pop_valid;
  logic [7:0] sp;
  logic       stack_err;

  modport master (
    output stack_op_ongoing, push_or_pop, bus_grant, push_pc, push_flags, mem_rd_data,
    input  stack_op_end, mem_addr, mem_wr_data, pop_pc, pop_flags, pop_valid, sp, stack_err
  );

  modport slave (
    input  stack_op_ongoing, push_or_pop, bus_grant, push_pc, push_flags, mem_rd_data,
    output stack_op_end, mem_addr, mem_wr_data, pop_pc, pop_flags, pop_valid, sp, stack_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack responder: runs the two-beat push/pop memory transfers for the CPU
// controller and owns the empty-descending stack pointer.
module stack_ctrl #(
  parameter logic [7:0] SP_INIT  = 8'hFF,
  parameter logic       PUSH_VAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1, ST_DONE} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_dir_push;
  logic       r_armed;
  logic [7:0] r_sp;
  logic [7:0] r_hold_pc;
  logic [7:0] r_hold_flags;
  logic [7:0] r_pop_pc;
  logic [7:0] r_pop_flags;
  logic       r_err;

  logic       w_start;
  logic       w_start_push;
  logic       w_beat0_grant;
  logic       w_beat1_grant;

  assign w_start       = (r_state == ST_IDLE) && bus.stack_op_ongoing && r_armed;
  assign w_start_push  = (bus.push_or_pop == PUSH_VAL);
  assign w_beat0_grant = (r_state == ST_BEAT0) && bus.stack_op_ongoing && bus.bus_grant;
  assign w_beat1_grant = (r_state == ST_BEAT1) && bus.stack_op_ongoing && bus.bus_grant;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_BEAT0;
      ST_BEAT0: begin
        if (!bus.stack_op_ongoing) w_state_nxt = ST_IDLE;
        else if (bus.bus_grant)    w_state_nxt = ST_BEAT1;
      end
      ST_BEAT1: begin
        if (!bus.stack_op_ongoing) w_state_nxt = ST_IDLE;
        else if (bus.bus_grant)    w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Pops read upward from sp+1 (flags first), pushes write downward from sp.
  always_comb begin
    bus.mem_addr    = r_sp;
    bus.mem_wr_data = 8'h00;
    case (r_state)
      ST_BEAT0: begin
        if (r_dir_push) begin
          bus.mem_addr    = r_sp;
          bus.mem_wr_data = bus.push_pc;
        end else begin
          bus.mem_addr    = r_sp + 8'd1;
        end
      end
      ST_BEAT1: begin
        if (r_dir_push) begin
          bus.mem_addr    = r_sp - 8'd1;
          bus.mem_wr_data = bus.push_flags;
        end else begin
          bus.mem_addr    = r_sp + 8'd2;
        end
      end
      default: ;
    endcase
  end

  // NOTE: asynchronous reset is in the sensitivity list and every register,
  // including the holding registers, returns to a known value on rst; state
  // is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dir_push   <= 1'b0;
      r_armed      <= 1'b1;
      r_sp         <= SP_INIT;
      r_hold_pc    <= 8'h00;
      r_hold_flags <= 8'h00;
      r_pop_pc     <= 8'h00;
      r_pop_flags  <= 8'h00;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Re-arm only after the controller has left its stack state.
      if (!bus.stack_op_ongoing) r_armed <= 1'b1;
      else if (w_start)          r_armed <= 1'b0;

      if (w_start) begin
        r_dir_push <= w_start_push;
        if ((w_start_push && (r_sp < 8'h01)) || (!w_start_push && (r_sp > 8'hFD)))
          r_err <= 1'b1;
      end

      if (w_beat0_grant && !r_dir_push) r_hold_flags <= bus.mem_rd_data;
      if (w_beat1_grant && !r_dir_push) r_hold_pc    <= bus.mem_rd_data;

      if (r_state == ST_DONE) begin
        if (r_dir_push) begin
          r_sp <= r_sp - 8'd2;
        end else begin
          r_sp        <= r_sp + 8'd2;
          r_pop_pc    <= r_hold_pc;
          r_pop_flags <= r_hold_flags;
        end
      end
    end
  end

  assign bus.stack_op_end = (r_state == ST_DONE);
  assign bus.pop_valid    = (r_state == ST_DONE) && !r_dir_push;
  assign bus.pop_pc       = r_pop_pc;
  assign bus.pop_flags    = r_pop_flags;
  assign bus.sp           = r_sp;
  assign bus.stack_err    = r_err;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: three instances (SP_INIT FF, 00, FE)
// share one stimulus driver; a beat scoreboard checks every granted access.
module tb_stack_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_ctrl_if bus_a ();
  stack_ctrl_if bus_lo ();
  stack_ctrl_if bus_hi ();

  stack_ctrl #(.SP_INIT(8'hFF), .PUSH_VAL(1'b1)) u_dut    (.clk(clk), .rst(rst), .bus(bus_a));
  stack_ctrl #(.SP_INIT(8'h00), .PUSH_VAL(1'b1)) u_dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));
  stack_ctrl #(.SP_INIT(8'hFE), .PUSH_VAL(1'b1)) u_dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));

  // Common stimulus; ongoing and grant reach only the selected instance.
  logic       t_ongoing, t_dir, t_grant;
  logic [7:0] t_pc, t_flags, t_rd;
  int         sel;

  assign bus_a.stack_op_ongoing  = t_ongoing && (sel == 0);
  assign bus_lo.stack_op_ongoing = t_ongoing && (sel == 1);
  assign bus_hi.stack_op_ongoing = t_ongoing && (sel == 2);
  assign bus_a.bus_grant  = t_grant && (sel == 0);
  assign bus_lo.bus_grant = t_grant && (sel == 1);
  assign bus_hi.bus_grant = t_grant && (sel == 2);
  assign bus_a.push_or_pop  = t_dir;
  assign bus_lo.push_or_pop = t_dir;
  assign bus_hi.push_or_pop = t_dir;
  assign bus_a.push_pc  = t_pc;
  assign bus_lo.push_pc = t_pc;
  assign bus_hi.push_pc = t_pc;
  assign bus_a.push_flags  = t_flags;
  assign bus_lo.push_flags = t_flags;
  assign bus_hi.push_flags = t_flags;
  assign bus_a.mem_rd_data  = t_rd;
  assign bus_lo.mem_rd_data = t_rd;
  assign bus_hi.mem_rd_data = t_rd;

  logic [7:0] o_addr, o_wd, o_sp, o_pc, o_flags;
  logic       o_end, o_valid, o_err;

  always_comb begin
    o_addr = bus_a.mem_addr; o_wd = bus_a.mem_wr_data; o_sp = bus_a.sp;
    o_pc = bus_a.pop_pc; o_flags = bus_a.pop_flags;
    o_end = bus_a.stack_op_end; o_valid = bus_a.pop_valid; o_err = bus_a.stack_err;
    if (sel == 1) begin
      o_addr = bus_lo.mem_addr; o_wd = bus_lo.mem_wr_data; o_sp = bus_lo.sp;
      o_pc = bus_lo.pop_pc; o_flags = bus_lo.pop_flags;
      o_end = bus_lo.stack_op_end; o_valid = bus_lo.pop_valid; o_err = bus_lo.stack_err;
    end else if (sel == 2) begin
      o_addr = bus_hi.mem_addr; o_wd = bus_hi.mem_wr_data; o_sp = bus_hi.sp;
      o_pc = bus_hi.pop_pc; o_flags = bus_hi.pop_flags;
      o_end = bus_hi.stack_op_end; o_valid = bus_hi.pop_valid; o_err = bus_hi.stack_err;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", name, act, exp, $time, sel);
    end
  endtask

  // Reference model: per-instance sp/err and a fake data memory.
  logic [7:0] m_sp  [3];
  logic       m_err [3];
  logic [7:0] tb_mem [256];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
  } beat_t;
  beat_t beat_q[$];
  beat_t mon_b;

  always @(negedge clk) begin
    if (t_grant) begin
      if (beat_q.size() == 0) begin
        check("beat_unexpected", 32'd1, 32'd0);
      end else begin
        mon_b = beat_q.pop_front();
        check("beat_addr", o_addr, mon_b.addr);
        check("beat_wdata", o_wd, mon_b.wdata);
      end
    end
  end

  task automatic run_op(input logic push, input logic [7:0] pc, input logic [7:0] flags,
                        input int stall0, input int stall1, input logic toggle, input int hold);
    logic [7:0] s, a0, a1, d0, d1, exp_sp, exp_pc, exp_flags, addr, data;
    int st;
    s = m_sp[sel];
    if (push) begin
      a0 = s; d0 = pc; a1 = s - 8'd1; d1 = flags;
      tb_mem[a0] = pc; tb_mem[a1] = flags;
      exp_sp = s - 8'd2; exp_pc = 8'h00; exp_flags = 8'h00;
      if (s == 8'h00) m_err[sel] = 1'b1;
    end else begin
      a0 = s + 8'd1; d0 = 8'h00; a1 = s + 8'd2; d1 = 8'h00;
      exp_flags = tb_mem[a0]; exp_pc = tb_mem[a1];
      exp_sp = s + 8'd2;
      if (s >= 8'hFE) m_err[sel] = 1'b1;
    end
    beat_q.push_back('{a0, d0});
    beat_q.push_back('{a1, d1});

    t_dir = push; t_pc = pc; t_flags = flags; t_grant = 1'b0; t_ongoing = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      st   = (b == 0) ? stall0 : stall1;
      addr = (b == 0) ? a0 : a1;
      data = (b == 0) ? d0 : d1;
      for (int k = 0; k < st; k++) begin
        if (toggle) t_dir = ~t_dir;
        @(negedge clk);
        check("stall_addr", o_addr, addr);
        check("stall_wdata", o_wd, data);
        check("stall_no_end", o_end, 1'b0);
        @(posedge clk); #1;
      end
      t_grant = 1'b1;
      t_rd = push ? 8'h00 : tb_mem[addr];
      @(negedge clk);
      check("beat_no_end", o_end, 1'b0);
      @(posedge clk); #1;
      t_grant = 1'b0;
    end
    @(negedge clk);
    check("end_pulse", o_end, 1'b1);
    check("pop_valid", o_valid, !push);
    check("sp_before_done", o_sp, s);
    t_ongoing = (hold > 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("end_clear", o_end, 1'b0);
    check("valid_clear", o_valid, 1'b0);
    check("sp", o_sp, exp_sp);
    check("stack_err", o_err, m_err[sel]);
    if (!push) begin
      check("pop_pc", o_pc, exp_pc);
      check("pop_flags", o_flags, exp_flags);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("held_no_end", o_end, 1'b0);
      check("held_idle_addr", o_addr, exp_sp);
      check("held_sp", o_sp, exp_sp);
    end
    t_ongoing = 1'b0;
    @(posedge clk); #1;
    m_sp[sel] = exp_sp;
  endtask

  typedef struct {
    logic       push;
    logic [7:0] pc;
    logic [7:0] flags;
    int         stall0;
    int         stall1;
    logic       toggle;
    int         hold;
    logic [7:0] exp_sp;
    logic [7:0] exp_pc;
    logic [7:0] exp_flags;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'h3C, 8'h15, 0, 0, 1'b0, 0, 8'hFD, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'hEE, 8'hDD, 0, 0, 1'b0, 0, 8'hFF, 8'h3C, 8'h15};
    vecs[2] = '{1'b1, 8'hA5, 8'h2A, 4, 4, 1'b1, 0, 8'hFD, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 8'h55, 8'h66, 1, 2, 1'b0, 2, 8'hFF, 8'hA5, 8'h2A};
    vecs[4] = '{1'b1, 8'h11, 8'h22, 0, 1, 1'b0, 0, 8'hFD, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 8'h33, 8'h04, 2, 0, 1'b1, 0, 8'hFB, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 8'h99, 8'h88, 0, 0, 1'b0, 0, 8'hFD, 8'h33, 8'h04};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 3, 0, 1'b1, 1, 8'hFF, 8'h11, 8'h22};

    for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'h5A;
    m_sp[0] = 8'hFF; m_sp[1] = 8'h00; m_sp[2] = 8'hFE;
    for (int i = 0; i < 3; i++) m_err[i] = 1'b0;

    sel = 0; t_ongoing = 1'b0; t_dir = 1'b0; t_grant = 1'b0;
    t_pc = 8'h00; t_flags = 8'h00; t_rd = 8'h00;
    rst = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      check("rst_sp", o_sp, m_sp[i]);
      check("rst_addr", o_addr, m_sp[i]);
      check("rst_wdata", o_wd, 8'h00);
      check("rst_err", o_err, 1'b0);
      check("rst_end", o_end, 1'b0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_pop_pc", o_pc, 8'h00);
      check("rst_pop_flags", o_flags, 8'h00);
    end
    sel = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven operations on the SP_INIT=FF instance.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].push, vecs[i].pc, vecs[i].flags, vecs[i].stall0, vecs[i].stall1,
             vecs[i].toggle, vecs[i].hold);
      check("tbl_sp", o_sp, vecs[i].exp_sp);
      check("tbl_err", o_err, 1'b0);
      if (!vecs[i].push) begin
        check("tbl_pop_pc", o_pc, vecs[i].exp_pc);
        check("tbl_pop_flags", o_flags, vecs[i].exp_flags);
      end
    end

    // Abort in BEAT1: no pulse, sp and pop outputs untouched.
    beat_q.push_back('{8'hFF, 8'h77});
    t_dir = 1'b1; t_pc = 8'h77; t_flags = 8'h66; t_ongoing = 1'b1;
    @(posedge clk); #1;
    t_grant = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    t_grant = 1'b0;
    @(negedge clk);
    check("abort_beat1_addr", o_addr, 8'hFE);
    check("abort_beat1_wdata", o_wd, 8'h66);
    t_ongoing = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_end", o_end, 1'b0);
      check("abort_no_valid", o_valid, 1'b0);
      check("abort_idle_addr", o_addr, 8'hFF);
      check("abort_idle_wdata", o_wd, 8'h00);
      check("abort_sp", o_sp, 8'hFF);
      check("abort_pop_pc", o_pc, 8'h11);
      check("abort_pop_flags", o_flags, 8'h22);
    end
    @(posedge clk); #1;

    // Underflow on the FF instance: reads wrap to 00/01.
    run_op(1'b0, 8'h12, 8'h34, 0, 0, 1'b0, 0);
    check("uflow_sp", o_sp, 8'h01);
    check("uflow_err", o_err, 1'b1);

    // Overflow at sp=00, then underflow at sp=FE, on their own instances.
    sel = 1; #1;
    check("lo_err_before", o_err, 1'b0);
    run_op(1'b1, 8'hC3, 8'h3F, 0, 0, 1'b0, 0);
    check("oflow_sp", o_sp, 8'hFE);
    check("oflow_err", o_err, 1'b1);
    sel = 2; #1;
    check("hi_err_before", o_err, 1'b0);
    run_op(1'b0, 8'h00, 8'h00, 0, 0, 1'b0, 0);
    check("hi_uflow_sp", o_sp, 8'h00);
    check("hi_uflow_err", o_err, 1'b1);

    // Reset asserted while in BEAT0 of a push.
    sel = 0; #1;
    t_dir = 1'b1; t_pc = 8'h9A; t_flags = 8'hBC; t_ongoing = 1'b1;
    @(posedge clk); #1;
    check("rst_beat0_wdata", o_wd, 8'h9A);
    rst = 1'b1; #1;
    check("midrst_sp", o_sp, 8'hFF);
    check("midrst_err", o_err, 1'b0);
    check("midrst_addr", o_addr, 8'hFF);
    check("midrst_wdata", o_wd, 8'h00);
    check("midrst_end", o_end, 1'b0);
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_pop_pc", o_pc, 8'h00);
    check("midrst_pop_flags", o_flags, 8'h00);
    t_ongoing = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    m_sp[0] = 8'hFF; m_err[0] = 1'b0;
    run_op(1'b1, 8'h01, 8'h02, 0, 0, 1'b0, 0);
    check("post_rst_sp", o_sp, 8'hFD);

    check("beat_q_empty", beat_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
